keypad_encoder_db: RTL
======================

KEYPAD_ENCODER_DB -- requirements
Module: keypad_encoder_db

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 10, number of one-hot key inputs; legal range 2..16.
REQ-002 The block SHALL have parameter DW, default 4, code width; elaboration SHALL fail if N_KEYS > 2**DW.
REQ-003 The block SHALL have parameter DB_CYCLES, default 4, debounce length in clocks; legal range 1..255.
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 0, auto-repeat period in clocks; 0 disables repeat; legal range 0..65535.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all flops updating on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port key, input, N_KEYS bits: asynchronous raw key lines, bit i high = key i pressed.
REQ-008 The block SHALL have port enbn, input, 1 bit: active-low enable, where 1 means disabled.
REQ-009 The block SHALL have port D, output, DW bits: binary index of the last accepted key.
REQ-010 The block SHALL have port loadn, output, 1 bit: active-low one-cycle strobe marking a new accepted code.
REQ-011 The block SHALL have port pgt, output, 1 bit: active-high one-cycle strobe in the cycle after loadn is low.
REQ-012 The block SHALL have port err, output, 1 bit: active-high one-cycle pulse on multi-key detection.

Function
REQ-013 key SHALL pass through a 2-flop synchroniser; all decisions SHALL use the synchronised value ks.
REQ-014 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, HELD, REL_DB.
REQ-015 In IDLE, a one-hot ks SHALL capture the key index, load the counter to 1, and move to DEBOUNCE; ks==0 SHALL stay in IDLE.
REQ-016 In DEBOUNCE, a ks equal to the captured one-hot SHALL increment the counter; a different one-hot value SHALL recapture it and reload the counter to 1; ks==0 SHALL return to IDLE.
REQ-017 When the counter reaches DB_CYCLES in DEBOUNCE, the block SHALL load D with the captured index, drive loadn low for exactly one cycle, and enter HELD.
REQ-018 pgt SHALL be high for exactly the one cycle following the loadn-low cycle; loadn and pgt SHALL never be active in the same cycle.
REQ-019 Latency: for a key stable from before rising edge E, loadn SHALL be low in the cycle following edge E+1+DB_CYCLES.
REQ-020 D SHALL change only in the loadn-low cycle and SHALL otherwise hold, including across release and disable.
REQ-021 In IDLE or DEBOUNCE, ks with two or more bits set SHALL pulse err for one cycle, suppress loadn, and go to REL_DB.
REQ-022 In HELD, when REPEAT_CYCLES > 0 and ks is unchanged, the block SHALL re-issue the loadn/pgt pair every REPEAT_CYCLES clocks with D unchanged; when REPEAT_CYCLES = 0, it SHALL issue no repeat.
REQ-023 In HELD, any ks different from the captured value, including extra keys, SHALL move to REL_DB with no strobe.
REQ-024 In REL_DB, DB_CYCLES consecutive cycles of ks==0 SHALL return the FSM to IDLE; any nonzero ks SHALL reset the release counter.
REQ-025 enbn=1 SHALL force the FSM to IDLE and clear the counters at the next edge; while enbn=1, loadn SHALL be 1, pgt 0, and err 0; ks SHALL keep sampling.
REQ-026 When enbn and a debounce completion occur on the same edge, enbn SHALL win and no strobe SHALL be issued.
REQ-027 Counters SHALL saturate and never wrap.

Reset
REQ-028 rst=1 at a rising edge SHALL set D=0, loadn=1, pgt=0, err=0, FSM=IDLE, all counters and synchroniser flops to 0.
REQ-029 rst SHALL take priority over enbn and key activity at the same edge.
REQ-030 rst asserted mid-DEBOUNCE or mid-HELD SHALL abort with no strobe; the same key, still held after reset release, SHALL be accepted only after a full new debounce.

Verification
REQ-031 Defaults, enbn=0: key=10'b1000000000 held 20 cycles -> one loadn-low at edge E+5, D=4'd9, pgt the next cycle, no repeat.
REQ-032 Sequence 9, 8, 1, each held 10 cycles with 10 idle cycles between -> three strobes with D=9, 8, 1 in order.
REQ-033 key=10'b0000000110 -> err pulses once; no loadn; D unchanged; after release and key 3 pressed -> D=3.
REQ-034 Key 5 bounces 0/1 every 2 cycles for 12 cycles, then holds stable -> exactly one strobe, D=5, only after the stable period.
REQ-035 REPEAT_CYCLES=8, key 2 held 40 cycles -> first strobe at E+5, then repeats every 8 cycles, all with D=2.
REQ-036 enbn=1 raised during DEBOUNCE, and rst pulsed during HELD -> no strobe in either case; after rst, D=0, loadn=1, pgt=0.

Source files
------------

// File: rtl/keypad_encoder_db.sv
// Keypad encoder with debounce: synchronises one-hot raw key lines, debounces
// a single pressed key, latches its binary index on D and signals each newly
// accepted code with a loadn/pgt strobe pair. Optional auto-repeat while held.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no key seen, waiting for a one-hot ks
// DEBOUNCE | candidate key captured, counting consecutive stable cycles
// HELD     | key accepted and still held, optional auto-repeat running
// REL_DB   | waiting for DB_CYCLES consecutive all-released cycles
module keypad_encoder_db #(
   parameter int N_KEYS        = 10,
   parameter int DW            = 4,
   parameter int DB_CYCLES     = 4,
   parameter int REPEAT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key,
   input  logic              enbn,
   output logic [DW-1:0]     D,
   output logic              loadn,
   output logic              pgt,
   output logic              err
);

   generate
      if (N_KEYS > (1 << DW)) begin : g_bad_dw
         $error("keypad_encoder_db: N_KEYS does not fit in DW bits");
      end
      if (N_KEYS < 2 || N_KEYS > 16) begin : g_bad_nkeys
         $error("keypad_encoder_db: N_KEYS out of range 2..16");
      end
      if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db
         $error("keypad_encoder_db: DB_CYCLES out of range 1..255");
      end
      if (REPEAT_CYCLES < 0 || REPEAT_CYCLES > 65535) begin : g_bad_rep
         $error("keypad_encoder_db: REPEAT_CYCLES out of range 0..65535");
      end
   endgenerate

   // A repeat period of 1 would overlap loadn with the previous pgt, so the
   // shortest usable period is 2.
   localparam int                REP_EFF = (REPEAT_CYCLES == 1) ? 2 : REPEAT_CYCLES;
   localparam logic [7:0]        DB_L    = 8'(DB_CYCLES);
   localparam logic [15:0]       REP_L   = 16'(REP_EFF);
   localparam logic [N_KEYS-1:0] ONE     = N_KEYS'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   state_t            st_q, st_nxt;
   logic [N_KEYS-1:0] s1_q, ks_q;
   logic [N_KEYS-1:0] cap_q, cap_nxt;
   logic [7:0]        cnt_q, cnt_nxt, cnt_inc;
   logic [15:0]       rep_q, rep_nxt, rep_inc;
   logic [DW-1:0]     d_q, d_nxt, ks_idx;
   logic              stb_q, pgt_q, err_q;
   logic              strobe, err_set;
   logic              ks_zero, ks_one, ks_multi;

   assign ks_zero  = (ks_q == '0);
   assign ks_one   = !ks_zero && ((ks_q & (ks_q - ONE)) == '0);
   assign ks_multi = !ks_zero && !ks_one;

   assign cnt_inc = (cnt_q == 8'hFF)    ? cnt_q : cnt_q + 8'd1;
   assign rep_inc = (rep_q == 16'hFFFF) ? rep_q : rep_q + 16'd1;

   // Binary index of the synchronised key (meaningful only when one-hot).
   always_comb begin
      ks_idx = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (ks_q[i]) ks_idx = DW'(i);
      end
   end

   // Next-state, counter and strobe decisions.
   always_comb begin
      st_nxt  = st_q;
      cnt_nxt = cnt_q;
      rep_nxt = rep_q;
      cap_nxt = cap_q;
      d_nxt   = d_q;
      strobe  = 1'b0;
      err_set = 1'b0;
      if (enbn) begin
         st_nxt  = IDLE;
         cnt_nxt = '0;
         rep_nxt = '0;
      end else begin
         unique case (st_q)
            IDLE, DEBOUNCE: begin
               if (ks_multi) begin
                  err_set = 1'b1;
                  st_nxt  = REL_DB;
                  cnt_nxt = '0;
               end else if (ks_zero) begin
                  st_nxt  = IDLE;
                  cnt_nxt = '0;
               end else begin
                  st_nxt = DEBOUNCE;
                  if (st_q == DEBOUNCE && ks_q == cap_q) begin
                     cnt_nxt = cnt_inc;
                  end else begin
                     cap_nxt = ks_q;
                     cnt_nxt = 8'd1;
                  end
                  if (cnt_nxt == DB_L) begin
                     strobe  = 1'b1;
                     d_nxt   = ks_idx;
                     st_nxt  = HELD;
                     cnt_nxt = '0;
                     rep_nxt = '0;
                  end
               end
            end
            HELD: begin
               if (ks_q != cap_q) begin
                  st_nxt  = REL_DB;
                  cnt_nxt = '0;
                  rep_nxt = '0;
               end else if (REPEAT_CYCLES > 0) begin
                  rep_nxt = rep_inc;
                  if (rep_inc == REP_L) begin
                     strobe  = 1'b1;
                     rep_nxt = '0;
                  end
               end
            end
            REL_DB: begin
               if (ks_zero) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == DB_L) begin
                     st_nxt  = IDLE;
                     cnt_nxt = '0;
                  end
               end else begin
                  cnt_nxt = '0;
               end
            end
            default: st_nxt = IDLE;
         endcase
      end
   end

   // Synchroniser, FSM state, counters and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= '0;
         ks_q  <= '0;
         st_q  <= IDLE;
         cnt_q <= '0;
         rep_q <= '0;
         cap_q <= '0;
         d_q   <= '0;
         stb_q <= 1'b0;
         pgt_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         s1_q  <= key;
         ks_q  <= s1_q;
         st_q  <= st_nxt;
         cnt_q <= cnt_nxt;
         rep_q <= rep_nxt;
         cap_q <= cap_nxt;
         d_q   <= d_nxt;
         stb_q <= strobe;
         pgt_q <= stb_q;
         err_q <= err_set;
      end
   end

   // Disable masks all strobes immediately, not just from the next edge.
   assign D     = d_q;
   assign loadn = ~stb_q | enbn;
   assign pgt   = pgt_q & ~enbn;
   assign err   = err_q & ~enbn;

endmodule
